// File: rtl/vram_pkg.sv
// Shared constants, state encoding and helpers for the VRAM write engine.
package vram_pkg;

  localparam int unsigned H_PIXELS = 128;
  localparam int unsigned V_PIXELS = 96;
  localparam int unsigned ADDR_W   = 14;

  // Last on-screen address; everything above it is off the 96-row frame.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIXELS * V_PIXELS - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StFill  = 2'd2
  } state_e;

  // {r, g, b}
  typedef logic [2:0] rgb_t;

  // Row-major with a power-of-two stride, so the address is a plain concatenation.
  function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [6:0] x, input logic [6:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/vram_fill_counter.sv
// Frame-walk address counter used by the fill engine; flags the last on-screen address.
module vram_fill_counter
  import vram_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] count,
  output logic              tc
);

  // Count up on each issued fill write; clear restarts the walk at address 0.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + ADDR_W'(1);
    end
  end

  assign tc = (count == LAST_ADDR);

endmodule

// File: rtl/vram_writer.sv
// Write-side engine for the 128x96 3-bit-RGB video memory.
// Accepts pixel commands on a valid/ready handshake and issues them only inside the
// display controller's write window. Define VRAM_WRITER_FILL_EN to build the
// whole-frame fill engine (FILL state, address counter, colour latch, fill_done).
module vram_writer #(
  parameter int unsigned H_PIXELS = 128,
  parameter int unsigned V_PIXELS = 96,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [$clog2(H_PIXELS)-1:0] cmd_x,
  input  logic [6:0]                  cmd_y,
  input  logic [2:0]                  cmd_rgb,
  input  logic                        fill_start,
  input  logic [2:0]                  fill_rgb,
  input  logic                        wr_allow,
  output logic                        vram_we,
  output logic [ADDR_W-1:0]           vram_addr,
  output logic [2:0]                  vram_rgb,
  output logic                        busy,
  output logic                        fill_done,
  output logic                        oob_err
);

  import vram_pkg::*;

  localparam logic [6:0] YLim = 7'(V_PIXELS);

  state_e     state_q;
  logic [6:0] x_q;
  logic [6:0] y_q;
  rgb_t       rgb_q;

`ifdef VRAM_WRITER_FILL_EN
  rgb_t              fill_rgb_q;
  logic [ADDR_W-1:0] fill_cnt;
  logic              fill_tc;

  vram_fill_counter u_fill_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     ((state_q == StIdle) && fill_start),
    .en      ((state_q == StFill) && wr_allow),
    .count   (fill_cnt),
    .tc      (fill_tc)
  );
`else
  logic unused_fill;
  assign unused_fill = ^{fill_start, fill_rgb};
  assign fill_done   = 1'b0;
`endif

  // Control FSM; every output is a register and the strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cmd_ready  <= 1'b0;
      busy       <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_rgb   <= '0;
      oob_err    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      rgb_q      <= '0;
`ifdef VRAM_WRITER_FILL_EN
      fill_done  <= 1'b0;
      fill_rgb_q <= '0;
`endif
    end else begin
      vram_we <= 1'b0;
      oob_err <= 1'b0;
`ifdef VRAM_WRITER_FILL_EN
      fill_done <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
`ifdef VRAM_WRITER_FILL_EN
          // A fill request takes priority over a command presented in the same cycle.
          if (fill_start) begin
            state_q    <= StFill;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            fill_rgb_q <= fill_rgb;
          end else
`endif
          if (cmd_valid && cmd_ready) begin
            if (cmd_y < YLim) begin
              state_q   <= StWrite;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
              x_q       <= 7'(cmd_x);
              y_q       <= cmd_y;
              rgb_q     <= cmd_rgb;
            end else begin
              // Off-screen row: consume the command but flag it instead of writing.
              oob_err <= 1'b1;
            end
          end
        end
        StWrite: begin
          if (wr_allow) begin
            vram_we   <= 1'b1;
            vram_addr <= ADDR_W'(xy_to_addr(x_q, y_q));
            vram_rgb  <= rgb_q;
            state_q   <= StIdle;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
`ifdef VRAM_WRITER_FILL_EN
        StFill: begin
          if (wr_allow) begin
            vram_we   <= 1'b1;
            vram_addr <= ADDR_W'(fill_cnt);
            vram_rgb  <= fill_rgb_q;
            if (fill_tc) begin
              fill_done <= 1'b1;
              state_q   <= StIdle;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
`endif
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_writer.sv
// Self-checking bench for vram_writer: a per-cycle vector table for the command
// path, then hand-written sequences for hold, reset and (when built) fill behaviour.
module tb_vram_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [2:0]  cmd_rgb;
  logic        fill_start;
  logic [2:0]  fill_rgb;
  logic        wr_allow;
  logic        vram_we;
  logic [13:0] vram_addr;
  logic [2:0]  vram_rgb;
  logic        busy;
  logic        fill_done;
  logic        oob_err;

  int n_checks = 0;
  int n_fail   = 0;

  vram_writer u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_rgb    (cmd_rgb),
    .fill_start (fill_start),
    .fill_rgb   (fill_rgb),
    .wr_allow   (wr_allow),
    .vram_we    (vram_we),
    .vram_addr  (vram_addr),
    .vram_rgb   (vram_rgb),
    .busy       (busy),
    .fill_done  (fill_done),
    .oob_err    (oob_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        valid;
    logic [6:0]  x;
    logic [6:0]  y;
    logic [2:0]  rgb;
    logic        allow;
    logic        e_we;
    logic [13:0] e_addr;
    logic [2:0]  e_rgb;
    logic        e_ready;
    logic        e_busy;
    logic        e_oob;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid  = 1'b0;
    cmd_x      = '0;
    cmd_y      = '0;
    cmd_rgb    = '0;
    fill_start = 1'b0;
    fill_rgb   = '0;
    wr_allow   = 1'b0;
  endtask

`ifdef VRAM_WRITER_FILL_EN
  // Runs one complete fill and checks ordering, colour, length and completion.
  task automatic run_fill(input logic [2:0] col, input bit with_cmd, input bit toggle,
                          input int exp_cycles);
    int  cyc  = 0;
    int  nw   = 0;
    int  bad  = 0;
    bit  done = 1'b0;
    bit  allow_now;
    fill_rgb   = col;
    fill_start = 1'b1;
    cmd_valid  = with_cmd;
    cmd_x      = 7'd9;
    cmd_y      = 7'd9;
    cmd_rgb    = 3'b111;
    wr_allow   = 1'b0;
    tick();
    fill_start = 1'b0;
    cmd_valid  = 1'b0;
    check("fill_start_ready", cmd_ready, 0);
    check("fill_start_busy", busy, 1);
    while (!done && cyc < 30000) begin
      allow_now = toggle ? (((cyc + 1) % 2) == 0) : 1'b1;
      wr_allow  = allow_now;
      tick();
      cyc++;
      if (vram_we) begin
        if (!allow_now || vram_addr != 14'(nw) || vram_rgb != col) bad++;
        nw++;
      end
      if (fill_done) begin
        done = 1'b1;
        if (!vram_we || vram_addr != 14'd12287) bad++;
      end
    end
    check("fill_cycles", cyc, exp_cycles);
    check("fill_writes", nw, 12288);
    check("fill_order_errs", bad, 0);
    wr_allow = 1'b1;
    tick();
    check("fill_after_we", vram_we, 0);
    check("fill_after_busy", busy, 0);
    check("fill_after_ready", cmd_ready, 1);
  endtask
`endif

  initial begin
    int n;
    int w;
    bit reached;

    //            valid x     y      rgb   allow we addr      rgb   rdy busy oob
    vecs[0]  = '{1'b1, 7'd5,   7'd2,  3'd5, 1'b1, 0, 14'd0,     3'd0, 0, 1, 0};
    vecs[1]  = '{1'b0, 7'd0,   7'd0,  3'd0, 1'b1, 1, 14'd261,   3'd5, 1, 0, 0};
    vecs[2]  = '{1'b0, 7'd0,   7'd0,  3'd0, 1'b0, 0, 14'd0,     3'd0, 1, 0, 0};
    vecs[3]  = '{1'b1, 7'd127, 7'd95, 3'd7, 1'b0, 0, 14'd0,     3'd0, 0, 1, 0};
    vecs[4]  = '{1'b0, 7'd0,   7'd0,  3'd0, 1'b0, 0, 14'd0,     3'd0, 0, 1, 0};
    vecs[5]  = '{1'b0, 7'd0,   7'd0,  3'd0, 1'b1, 1, 14'd12287, 3'd7, 1, 0, 0};
    vecs[6]  = '{1'b1, 7'd0,   7'd96, 3'd1, 1'b1, 0, 14'd0,     3'd0, 1, 0, 1};
    vecs[7]  = '{1'b1, 7'd0,   7'd127,3'd1, 1'b1, 0, 14'd0,     3'd0, 1, 0, 1};
    vecs[8]  = '{1'b0, 7'd0,   7'd0,  3'd0, 1'b1, 0, 14'd0,     3'd0, 1, 0, 0};
    vecs[9]  = '{1'b1, 7'd1,   7'd0,  3'd2, 1'b1, 0, 14'd0,     3'd0, 0, 1, 0};
    vecs[10] = '{1'b1, 7'd3,   7'd1,  3'd6, 1'b1, 1, 14'd1,     3'd2, 1, 0, 0};
    vecs[11] = '{1'b1, 7'd3,   7'd1,  3'd6, 1'b1, 0, 14'd0,     3'd0, 0, 1, 0};
    vecs[12] = '{1'b0, 7'd0,   7'd0,  3'd0, 1'b1, 1, 14'd131,   3'd6, 1, 0, 0};

    // Reset state
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    check("rst_ready", cmd_ready, 0);
    check("rst_we", vram_we, 0);
    check("rst_addr", vram_addr, 0);
    check("rst_rgb", vram_rgb, 0);
    check("rst_busy", busy, 0);
    check("rst_fill_done", fill_done, 0);
    check("rst_oob", oob_err, 0);
    reset_n = 1'b1;
    tick();
    check("post_rst_ready", cmd_ready, 1);

    // Command path vectors, one clock each
    for (int i = 0; i < 13; i++) begin
      cmd_valid = vecs[i].valid;
      cmd_x     = vecs[i].x;
      cmd_y     = vecs[i].y;
      cmd_rgb   = vecs[i].rgb;
      wr_allow  = vecs[i].allow;
      tick();
      check($sformatf("v%0d_we", i), vram_we, vecs[i].e_we);
      check($sformatf("v%0d_ready", i), cmd_ready, vecs[i].e_ready);
      check($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("v%0d_oob", i), oob_err, vecs[i].e_oob);
      check($sformatf("v%0d_fill_done", i), fill_done, 0);
      if (vecs[i].e_we) begin
        check($sformatf("v%0d_addr", i), vram_addr, vecs[i].e_addr);
        check($sformatf("v%0d_rgb", i), vram_rgb, vecs[i].e_rgb);
      end
    end

    // Write window closed for 10 cycles: command held, one write after it opens
    idle_inputs();
    cmd_valid = 1'b1;
    cmd_x     = 7'd5;
    cmd_y     = 7'd2;
    cmd_rgb   = 3'b101;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    w = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) n++;
      if (vram_we) w++;
    end
    check("hold_busy_cycles", n, 10);
    check("hold_writes", w, 0);
    wr_allow = 1'b1;
    tick();
    check("hold_we", vram_we, 1);
    check("hold_addr", vram_addr, 261);
    check("hold_rgb", vram_rgb, 5);
    tick();
    check("hold_single_we", vram_we, 0);
    check("hold_ready", cmd_ready, 1);

    // Reset while a command is pending
    idle_inputs();
    cmd_valid = 1'b1;
    cmd_x     = 7'd7;
    cmd_y     = 7'd7;
    cmd_rgb   = 3'b011;
    tick();
    check("rstw_busy", busy, 1);
    cmd_valid = 1'b0;
    wr_allow  = 1'b1;
    reset_n   = 1'b0;
    tick();
    check("rstw_we", vram_we, 0);
    check("rstw_busy_clr", busy, 0);
    reset_n = 1'b1;
    tick();
    check("rstw_ready", cmd_ready, 1);
    check("rstw_no_late_we", vram_we, 0);

`ifdef VRAM_WRITER_FILL_EN
    // Full fill, started together with a command that must lose
    run_fill(3'b010, 1'b1, 1'b0, 12288);
    // Fill with the write window toggling every cycle
    run_fill(3'b110, 1'b0, 1'b1, 24576);

    // Reset partway through a fill
    idle_inputs();
    fill_rgb   = 3'b001;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    wr_allow   = 1'b1;
    reached    = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      tick();
      if (vram_we && vram_addr == 14'd100) reached = 1'b1;
    end
    check("rstf_reached_100", reached, 1);
    reset_n = 1'b0;
    tick();
    check("rstf_we", vram_we, 0);
    check("rstf_busy", busy, 0);
    reset_n = 1'b1;
    tick();
    check("rstf_ready", cmd_ready, 1);
    check("rstf_busy_idle", busy, 0);
    w = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (vram_we) w++;
    end
    check("rstf_no_writes", w, 0);
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    tick();
    check("rstf_restart_we", vram_we, 1);
    check("rstf_restart_addr", vram_addr, 0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
`else
    // Without the fill engine, fill_start is ignored entirely
    idle_inputs();
    wr_allow   = 1'b1;
    fill_rgb   = 3'b010;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    check("nofill_ready", cmd_ready, 1);
    check("nofill_busy", busy, 0);
    tick();
    check("nofill_we", vram_we, 0);
    check("nofill_done", fill_done, 0);
    // A command alongside fill_start is taken as a normal command
    fill_start = 1'b1;
    cmd_valid  = 1'b1;
    cmd_x      = 7'd4;
    cmd_y      = 7'd0;
    cmd_rgb    = 3'b001;
    tick();
    fill_start = 1'b0;
    cmd_valid  = 1'b0;
    check("nofill_cmd_ready", cmd_ready, 0);
    check("nofill_cmd_busy", busy, 1);
    tick();
    check("nofill_cmd_we", vram_we, 1);
    check("nofill_cmd_addr", vram_addr, 4);
    check("nofill_cmd_rgb", vram_rgb, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_writer.md
# vram_writer

Write-side engine for the 128×96, 3-bit-RGB video memory. The display path only reads this memory. This block is the writer on the VRAM write port:
- accepts single-pixel write commands over a valid/ready handshake;
- optionally clears or fills the whole frame with one colour;
- issues writes only while the display controller grants a write window (`wr_allow`).

## Interface
- `H_PIXELS`, default 128: columns; x occupies address bits [6:0].
- `V_PIXELS`, default 96: rows; valid y is 0..95.
- `ADDR_W`, default 14: VRAM address width; address = y*128 + x = {y, x}.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  a pixel command is presented.
- `cmd_ready`  out  1  the block accepts the command this cycle.
- `cmd_x`  in  7  pixel column.
- `cmd_y`  in  7  pixel row.
- `cmd_rgb`  in  3  {r,g,b} colour for the pixel.
- `fill_start`  in  1  one-cycle request to fill the whole frame.
- `fill_rgb`  in  3  fill colour, sampled together with `fill_start`.
- `wr_allow`  in  1  write window from the display controller (blanking).
- `vram_we`  out  1  write strobe to the VRAM write port.
- `vram_addr`  out  14  write address.
- `vram_rgb`  out  3  write data: bit 2 goes to the red plane, bit 1 to green, bit 0 to blue.
- `busy`  out  1  a write or fill is pending or in progress.
- `fill_done`  out  1  one-cycle pulse when the last fill write is issued.
- `oob_err`  out  1  one-cycle pulse when a command is dropped because y ≥ 96.

## Operation
- States:
  - IDLE: `cmd_ready`=1, `busy`=0.
  - WRITE: holds one accepted command.
  - FILL: walks the frame with an address counter.
- IDLE → FILL when `fill_start`=1. `fill_start` beats `cmd_valid` when both arrive in the same cycle; the command is not accepted (`cmd_ready` drops next cycle).
- IDLE → WRITE on a handshake (`cmd_valid` & `cmd_ready`), provided `cmd_y` < 96. x, y and rgb are registered at that edge.
- Command with `cmd_y` ≥ 96:
  - it is still accepted;
  - `oob_err` pulses for one cycle;
  - no write is issued and the state stays IDLE.
- WRITE: at the first edge where `wr_allow`=1:
  - register `vram_we`=1, `vram_addr`={y,x} and `vram_rgb`=rgb;
  - go to IDLE.
  - While `wr_allow`=0 the command is held and `busy`=1.
- FILL: the counter starts at 0. At each edge where `wr_allow`=1:
  - issue a write to the counter address with `fill_rgb` latched at start;
  - increment the counter.
  - When `wr_allow`=0 the fill pauses with no write and the counter is kept.
- Fill end: the write to address 12287 also asserts `fill_done` and returns to IDLE. Addresses 12288..16383 are never written.
- `fill_start` is ignored outside IDLE. `cmd_ready`=0 outside IDLE.
- `vram_we` is high for exactly one cycle per write; it is 0 in every other cycle.

## Timing
- All outputs are registered.
- Reset values: `cmd_ready`=0 during reset, `vram_we`=0, `vram_addr`=0, `vram_rgb`=0, `busy`=0, `fill_done`=0, `oob_err`=0.
- `cmd_ready`=1 from the first cycle after `reset_n` rises.
- Single-write latency: command accepted at edge N; with `wr_allow`=1, `vram_we` is high in the cycle after edge N+1. `cmd_ready` returns at edge N+1.
- Peak throughput: 1 write per 2 cycles.
- Fill duration: 12288 cycles with `wr_allow` held high. Each cycle with `wr_allow` low adds exactly one cycle.
- Reset mid-write or mid-fill:
  - the pending command or fill is discarded;
  - the block is back in IDLE on the next edge;
  - no write is issued in the cycle after reset is sampled.

## Configuration
- `VRAM_WRITER_FILL_EN` defined: FILL state, address counter, `fill_done` and fill colour latch are built.
- Not defined:
  - `fill_start` and `fill_rgb` are ignored;
  - `fill_done` is tied to 0;
  - the state machine has IDLE and WRITE only.

## Structure
- Package `vram_pkg`:
  - `H_PIXELS`, `V_PIXELS`, `ADDR_W`;
  - last address 12287;
  - the state encoding;
  - the 3-bit rgb type and an x/y-to-address helper.
- Sub-module `vram_fill_counter`:
  - 14-bit counter with enable;
  - clear and terminal-count flag at 12287;
  - instantiated only under `VRAM_WRITER_FILL_EN`.

## Test plan
- Reset, then `cmd` x=5, y=2, rgb=3'b101, `wr_allow`=1 → `vram_we` for one cycle with addr=261, rgb=101. `cmd_ready` is low for exactly 1 cycle.
- Same command with `wr_allow`=0 for 10 cycles, then 1 → `busy` held high for 10 cycles. Exactly one write to addr 261, issued after `wr_allow` rises.
- `cmd` y=96 → `oob_err` pulse, no `vram_we`, `cmd_ready` stays 1.
- `fill_start`, rgb=3'b010, `wr_allow`=1:
  - 12288 writes to addresses 0..12287, all with rgb 010;
  - `fill_done` coincides with the addr-12287 write.
- Fill with `wr_allow` toggling every cycle → each address is written exactly once, in order, and the fill takes 24576 cycles. `fill_start` and `cmd_valid` together → fill wins and the command is not accepted.
- Reset asserted at fill address 100 → no further writes. After release: `cmd_ready`=1, `busy`=0, and a new fill restarts at address 0.
